// File: rtl/result_buffer.sv
// result_buffer: first-word-fall-through capture FIFO for single-cycle result pulses, with
// overflow tracking. Optional head parity output is enabled by RESULT_BUF_PARITY_EN.
module result_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_out,
  input  logic [DATA_W-1:0]          data_out,
  output logic                       m_valid,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_ovf
`ifdef RESULT_BUF_PARITY_EN
  ,
  output logic                       m_par
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
`ifdef RESULT_BUF_PARITY_EN
  localparam int unsigned EntryW = DATA_W + 1;
`else
  localparam int unsigned EntryW = DATA_W;
`endif

  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_e;

  logic [EntryW-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [LvlW-1:0]   r_level;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;

  occ_e              w_occ;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [EntryW-1:0] w_wr_entry;
  logic [EntryW-1:0] w_head;

  // Occupancy state is purely a decode of the level counter.
  always_comb begin
    w_occ = OccPartial;
    if (r_level == '0) begin
      w_occ = OccEmpty;
    end else if (r_level == LvlW'(DEPTH)) begin
      w_occ = OccFull;
    end
  end

  assign w_full  = (w_occ == OccFull);
  assign w_empty = (w_occ == OccEmpty);

  assign w_pop  = !w_empty && m_ready;
  assign w_push = valid_out && (!w_full || w_pop);
  assign w_drop = valid_out && w_full && !w_pop;

`ifdef RESULT_BUF_PARITY_EN
  assign w_wr_entry = {^data_out, data_out};
`else
  assign w_wr_entry = data_out;
`endif

  // Storage is deliberately not reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= r_level + LvlW'(w_push) - LvlW'(w_pop);
    end
  end

  // A drop in the same cycle as a clear wins: the clear is applied, then the drop counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign m_valid  = !w_empty;
  assign m_data   = w_head[DATA_W-1:0];
  assign level    = r_level;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

`ifdef RESULT_BUF_PARITY_EN
  assign m_par = !w_empty && w_head[DATA_W];
`endif

endmodule

// File: tb/tb_result_buffer.sv
// Directed self-checking bench for result_buffer at DEPTH=4; parity checks follow
// RESULT_BUF_PARITY_EN.
module tb_result_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_out = 1'b0;
  logic [DATA_W-1:0] data_out = '0;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b0;
  logic [2:0]        level;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              clr_ovf = 1'b0;
`ifdef RESULT_BUF_PARITY_EN
  logic              m_par;
`endif

  int n_checks = 0;
  int n_errors = 0;

  result_buffer #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_out(valid_out),
    .data_out (data_out),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
`ifdef RESULT_BUF_PARITY_EN
    ,
    .m_par    (m_par)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_out = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
`ifdef RESULT_BUF_PARITY_EN
    n_checks++; if (m_par !== 1'b0) begin n_errors++; $display("FAIL reset_m_par: got %b expected 0", m_par); end
`endif
    step();
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL idle_empty: got %b expected 1", empty); end
  endtask

  task automatic test_order();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      valid_out = 1'b1; data_out = exp_data[i];
      step();
    end
    valid_out = 1'b0;
    n_checks++; if (level !== 3'd3) begin n_errors++; $display("FAIL order_level_filled: got %0d expected 3", level); end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (m_data !== exp_data[i]) begin n_errors++; $display("FAIL order_data[%0d]: got %h expected %h", i, m_data, exp_data[i]); end
      n_checks++;
      if (level !== 3'(3 - i)) begin n_errors++; $display("FAIL order_level[%0d]: got %0d expected %0d", i, level, 3 - i); end
      step();
    end
    n_checks++; if (empty !== 1'b1 || level !== 3'd0) begin n_errors++; $display("FAIL order_empty: got empty=%b level=%0d expected empty=1 level=0", empty, level); end
    // m_ready held while empty must be ignored.
    step();
    m_ready = 1'b0;
    n_checks++; if (level !== 3'd0 || m_valid !== 1'b0) begin n_errors++; $display("FAIL order_idle_ready: got level=%0d m_valid=%b expected 0/0", level, m_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      valid_out = 1'b1; data_out = 32'hA0 + 32'(i);
      step();
    end
    valid_out = 1'b0;
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_checks++; if (drop_cnt !== 8'd2) begin n_errors++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m_data !== 32'hA0 + 32'(i)) begin n_errors++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, m_data, 32'hA0 + 32'(i)); end
      step();
    end
    m_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL ovf_drained_empty: got %b expected 1", empty); end
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_errors++; $display("FAIL ovf_clear: got overflow=%b drop_cnt=%0d expected 0/0", overflow, drop_cnt); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      valid_out = 1'b1; data_out = 32'hB0 + 32'(i);
      step();
    end
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL fpp_full: got %b expected 1", full); end
    data_out = 32'hB4; m_ready = 1'b1;
    step();
    valid_out = 1'b0; m_ready = 1'b0;
    n_checks++; if (level !== 3'd4) begin n_errors++; $display("FAIL fpp_level: got %0d expected 4", level); end
    n_checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_errors++; $display("FAIL fpp_no_drop: got overflow=%b drop_cnt=%0d expected 0/0", overflow, drop_cnt); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m_data !== 32'hB1 + 32'(i)) begin n_errors++; $display("FAIL fpp_drain[%0d]: got %h expected %h", i, m_data, 32'hB1 + 32'(i)); end
      step();
    end
    m_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL fpp_empty: got %b expected 1", empty); end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid_out = 1'b1; data_out = 32'hE0 + 32'(i);
      step();
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 32'hE0 + 32'(i) || level !== 3'd1) begin
        n_errors++;
        $display("FAIL b2b[%0d]: got valid=%b data=%h level=%0d expected 1/%h/1", i, m_valid, m_data, level, 32'hE0 + 32'(i));
      end
    end
    valid_out = 1'b0;
    step();
    m_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL b2b_empty: got %b expected 1", empty); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      valid_out = 1'b1; data_out = 32'hC0 + 32'(i);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      data_out = 32'hDEAD_0000 + 32'(i);
      step();
    end
    n_checks++; if (drop_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_drop_cnt: got %0d expected 255", drop_cnt); end
    n_checks++; if (level !== 3'd4 || m_data !== 32'hC0) begin n_errors++; $display("FAIL sat_contents: got level=%0d head=%h expected 4/c0", level, m_data); end
    clr_ovf = 1'b1;
    step();
    n_checks++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin n_errors++; $display("FAIL sat_clear_race: got drop_cnt=%0d overflow=%b expected 1/1", drop_cnt, overflow); end
    valid_out = 1'b0;
    step();
    clr_ovf = 1'b0;
    n_checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin n_errors++; $display("FAIL sat_clear: got drop_cnt=%0d overflow=%b expected 0/0", drop_cnt, overflow); end
    do_reset();
  endtask

  task automatic test_parity_reset();
    valid_out = 1'b1; data_out = 32'h7;
    step();
    data_out = 32'h3;
    step();
    valid_out = 1'b0;
    n_checks++; if (m_data !== 32'h7) begin n_errors++; $display("FAIL par_head0: got %h expected 7", m_data); end
`ifdef RESULT_BUF_PARITY_EN
    n_checks++; if (m_par !== 1'b1) begin n_errors++; $display("FAIL par_bit0: got %b expected 1", m_par); end
`endif
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_checks++; if (m_data !== 32'h3) begin n_errors++; $display("FAIL par_head1: got %h expected 3", m_data); end
`ifdef RESULT_BUF_PARITY_EN
    n_checks++; if (m_par !== 1'b0) begin n_errors++; $display("FAIL par_bit1: got %b expected 0", m_par); end
`endif
    valid_out = 1'b1; data_out = 32'hD0;
    step();
    valid_out = 1'b0;
    n_checks++; if (level !== 3'd2) begin n_errors++; $display("FAIL rst_pre_level: got %0d expected 2", level); end
    // Push and pop attempts coinciding with reset are ignored.
    rst = 1'b1; valid_out = 1'b1; data_out = 32'hD1; m_ready = 1'b1;
    step();
    rst = 1'b0; valid_out = 1'b0; m_ready = 1'b0;
    n_checks++; if (empty !== 1'b1 || m_valid !== 1'b0 || level !== 3'd0) begin n_errors++; $display("FAIL rst_mid: got empty=%b m_valid=%b level=%0d expected 1/0/0", empty, m_valid, level); end
`ifdef RESULT_BUF_PARITY_EN
    n_checks++; if (m_par !== 1'b0) begin n_errors++; $display("FAIL rst_mid_par: got %b expected 0", m_par); end
`endif
    step();
    n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL rst_stale: got %b expected 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_saturation();
    test_parity_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/result_buffer.md
# result_buffer

Downstream capture stage for the register-bank/ALU datapath. Samples every 32-bit result presented with `valid_out`/`data_out` into a DEPTH-entry first-word-fall-through FIFO, drains it through a ready/valid master port, and tracks results lost to overflow. It decouples the single-cycle result pulse from a consumer that may stall, such as a scoreboard port, bus bridge or UART packer.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DATA_W`, 32: result width; matches `data_out`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_out`  in  1  producer result strobe; single-cycle, no backpressure.
- `data_out`  in  DATA_W  producer result; sampled when `valid_out`=1.
- `m_valid`  out  1  head entry available.
- `m_data`  out  DATA_W  head entry.
- `m_ready`  in  1  consumer accepts head.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  `level`==DEPTH.
- `empty`  out  1  `level`==0.
- `overflow`  out  1  sticky; a result was dropped.
- `drop_cnt`  out  8  count of dropped results; saturates at 255.
- `clr_ovf`  in  1  clears `overflow` and `drop_cnt`.
- `m_par`  out  1  even parity of `m_data`; present only with `RESULT_BUF_PARITY_EN`.

## Operation
- Storage: DEPTH×DATA_W register array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1→0. `level` is a separate counter.
- pop = `m_valid` & `m_ready`.
- push = `valid_out` & (!`full` | pop). When full, a pop and a push in the same cycle are both taken. `level` stays at DEPTH, and the new word lands in the slot freed by the pop.
- drop = `valid_out` & `full` & !pop. On drop: the data is discarded, `overflow`←1, and `drop_cnt`←min(`drop_cnt`+1, 255). Pointers and `level` are unchanged.
- `level` next = `level` + push − pop.
- `m_valid` = !`empty`. `m_data` = mem[rd_ptr], which is the first-word-fall-through head.
- No bypass: a push into an empty FIFO is not visible on `m_valid` until the next cycle. `m_ready` while empty is ignored.
- `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- `clr_ovf`: `overflow`←0 and `drop_cnt`←0. If a drop occurs in the same cycle, the drop wins: `overflow`=1 and `drop_cnt`=1.
- No data FSM. The only control states are the occupancy states EMPTY, PARTIAL and FULL, all derived from `level`.

## Timing
- Reset (`rst`=1 at a clock edge): pointers=0, `level`=0, `empty`=1, `full`=0, `m_valid`=0, `overflow`=0, `drop_cnt`=0, `m_par`=0. `m_data` follows mem[0] and is don't-care; memory contents are not reset.
- A `valid_out`/`m_ready` that coincides with `rst` is ignored. Reset mid-stream discards all stored entries.
- Latency: a word pushed at edge N drives `m_valid`=1 and `m_data` from edge N onward. That is a one-cycle input-to-output delay.
- Throughput: one push and one pop per cycle, sustained, at any occupancy.
- `full`, `empty`, `level`, `overflow` and `drop_cnt` are all registered or derived from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- `RESULT_BUF_PARITY_EN` defined:
  - Each entry stores DATA_W+1 bits; the extra bit is ^`data_out`, computed at push.
  - `m_par` outputs the stored bit of the head entry.
- `RESULT_BUF_PARITY_EN` undefined: the `m_par` port and the parity storage are absent. Behaviour is otherwise identical.

## Test plan
- Reset then idle: after `rst` held 2 cycles → `empty`=1, `m_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0.
- Ordering, DEPTH=4, `m_ready`=0: push 0x0000_0011, 0x0000_0022, 0x0000_0033 on consecutive cycles, then `m_ready`=1 → `m_data` sequence 0x11, 0x22, 0x33. `level` goes 3→2→1→0, then `empty`=1.
- Overflow, DEPTH=4, `m_ready`=0: push 6 words 0xA0..0xA5 → `full`=1, `overflow`=1, `drop_cnt`=2. Drain yields 0xA0..0xA3 only. Then `clr_ovf` → `overflow`=0, `drop_cnt`=0.
- Full with simultaneous push+pop: FIFO full with 0xB0..0xB3; push 0xB4 with `m_ready`=1 → no drop, `level` stays 4. Drain yields 0xB1..0xB4.
- Saturation and clear race: 300 drops while full → `drop_cnt`=255. Then `clr_ovf` in the same cycle as a drop → `drop_cnt`=1, `overflow`=1.
- Parity (macro on) and reset mid-stream: push 0x0000_0007 → `m_par`=1. Push 0x0000_0003 → `m_par`=0 when that word is at the head. Assert `rst` with 2 entries stored → `empty`=1 next cycle and no stale data is presented.
